dart_throw_sequencer: RTL and testbench
=======================================

DART_THROW_SEQUENCER -- requirements
Module: dart_throw_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset as elsewhere in the codebase.
REQ-002 Parameters SHALL be as follows (name, default, meaning):
- COORD_W, 8: width of the x and y coordinates.
- N_PLAYERS, 2: number of players, legal range 2..4.
- THROWS_PER_TURN, 3: darts per turn, legal range 1..7.
- DEPTH, 32: number of script entries; must be a power of two.
- TIMEOUT, 1023: cycles allowed in WAIT before an error.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: system clock.
- reset, in, 1: asynchronous active-low reset.
- load_en_i, in, 1: write one script entry.
- load_addr_i, in, log2(DEPTH): script write address.
- load_x_i, in, COORD_W: x coordinate to write.
- load_y_i, in, COORD_W: y coordinate to write.
- script_len_i, in, log2(DEPTH)+1: number of valid entries, sampled on start.
- start_i, in, 1: begin playback.
- player_done_i, in, N_PLAYERS: per-player throw-processed flags.
- bust_i, in, 1: the current turn busts; qualified by the done edge.
- game_set_i, in, 1: game over.
- dart_come_o, out, 1: dart present.
- dart_position_x_o, out, COORD_W: x coordinate of the presented dart.
- dart_position_y_o, out, COORD_W: y coordinate of the presented dart.
- cur_player_o, out, log2(N_PLAYERS): player whose turn it is.
- throw_idx_o, out, 3: throw number within the turn, starting at 0.
- busy_o, out, 1: playback in progress.
- finished_o, out, 1: playback ended normally.
- timeout_o, out, 1: playback aborted on timeout.
- wrong_done_o, out, 1: one-cycle pulse on an unexpected done edge.

Function
REQ-004 The script SHALL be a DEPTH x 2*COORD_W register array; load_en_i SHALL write it only in IDLE, DONE or ERROR, and SHALL be ignored otherwise.
REQ-005 The FSM SHALL have the states IDLE, FETCH, WAIT, ADVANCE, DONE and ERROR.
REQ-006 On start_i in IDLE, DONE or ERROR, the block SHALL:
- latch script_len_i;
- clear the pointer, cur_player and throw_idx;
- clear the finished and timeout flags;
- go to FETCH.
A start_i with script_len_i=0 SHALL go directly to DONE.
REQ-007 start_i SHALL be ignored in FETCH, WAIT and ADVANCE.
REQ-008 FETCH SHALL last exactly one cycle and SHALL register the script entry at the pointer onto dart_position_x_o and dart_position_y_o.
REQ-009 In WAIT, dart_come_o SHALL be 1 and the positions SHALL be held stable; dart_come_o SHALL be 0 in every other state.
REQ-010 A done edge SHALL be player_done_i[k] & ~player_done_q[k], where player_done_q is a one-cycle registered copy of player_done_i; edges SHALL only be evaluated in WAIT.
REQ-011 An edge on k == cur_player SHALL move the FSM to ADVANCE on the next cycle.
REQ-012 An edge on k != cur_player SHALL pulse wrong_done_o for one cycle and SHALL NOT change the state.
REQ-013 Simultaneous edges SHALL act on the cur_player bit and flag the other bits.
REQ-014 ADVANCE SHALL last one cycle and SHALL increment the pointer.
REQ-015 ADVANCE SHALL end the turn if throw_idx == THROWS_PER_TURN-1, or if bust_i was 1 in the cycle the edge was accepted.
- Turn end: throw_idx becomes 0 and cur_player advances modulo N_PLAYERS, so N_PLAYERS-1 wraps to 0.
- Otherwise: throw_idx increments.
REQ-016 After ADVANCE, the FSM SHALL go to DONE if the pointer equals the latched length, and to FETCH otherwise.
REQ-017 game_set_i=1 in FETCH, WAIT or ADVANCE SHALL force DONE on the next cycle, taking priority over a simultaneous done edge and over a timeout.
REQ-018 A cycle counter SHALL run in WAIT and clear on entry to WAIT; when it reaches TIMEOUT, the FSM SHALL go to ERROR and set timeout_o.
REQ-019 DONE SHALL set finished_o; finished_o and timeout_o SHALL hold until the next accepted start_i.
REQ-020 busy_o SHALL be 1 exactly in FETCH, WAIT and ADVANCE.
REQ-021 The latency from an accepted done edge to the next dart_come_o=1 SHALL be 3 cycles: ADVANCE, FETCH, then WAIT.

Reset
REQ-022 While reset=0, the block SHALL:
- enter IDLE;
- drive every output to 0;
- clear the pointer, counters and player_done_q.
REQ-023 The script contents SHALL NOT be reset.
REQ-024 An assertion of reset mid-playback SHALL abort the playback immediately, with no completion flag set.

Verification
REQ-025 Normal game: N_PLAYERS=2, six entries (13,2), (14,2), (14,3), (13,2), (24,4), (13,2), with a done pulse per throw. Required: cur_player 0,0,0,1,1,1; positions in script order; finished_o=1 after the sixth edge.
REQ-026 Bust: a done with bust_i=1 on throw_idx=0 of player 0. Required: the next FETCH shows cur_player=1 and throw_idx=0.
REQ-027 Wrong player: player_done_i[1] edge while cur_player=0. Required: a one-cycle wrong_done_o pulse; dart_come_o stays 1; the position is unchanged.
REQ-028 Timeout: TIMEOUT=15 with no done. Required: ERROR after 15 cycles in WAIT; timeout_o=1; dart_come_o=0; a new start_i clears timeout_o.
REQ-029 game_set: game_set_i in the same cycle as a done edge. Required: DONE; the pointer is not incremented; finished_o=1.
REQ-030 Reset in WAIT: reset=0 mid-playback. Required: all outputs 0 asynchronously; after release the FSM is in IDLE, and re-starting replays the script from entry 0.

Source files
------------

// File: rtl/dart_throw_sequencer.sv
// Dart throw playback sequencer. It replays a loaded script of dart positions one at a time.
// It waits for the current player's done edge, then rotates throws and players until the script ends.
module dart_throw_sequencer #(
  parameter int COORD_W         = 8,
  parameter int N_PLAYERS       = 2,
  parameter int THROWS_PER_TURN = 3,
  parameter int DEPTH           = 32,
  parameter int TIMEOUT         = 1023
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_en_i,
  input  logic [$clog2(DEPTH)-1:0]     load_addr_i,
  input  logic [COORD_W-1:0]           load_x_i,
  input  logic [COORD_W-1:0]           load_y_i,
  input  logic [$clog2(DEPTH):0]       script_len_i,
  input  logic                         start_i,
  input  logic [N_PLAYERS-1:0]         player_done_i,
  input  logic                         bust_i,
  input  logic                         game_set_i,
  output logic                         dart_come_o,
  output logic [COORD_W-1:0]           dart_position_x_o,
  output logic [COORD_W-1:0]           dart_position_y_o,
  output logic [$clog2(N_PLAYERS)-1:0] cur_player_o,
  output logic [2:0]                   throw_idx_o,
  output logic                         busy_o,
  output logic                         finished_o,
  output logic                         timeout_o,
  output logic                         wrong_done_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(N_PLAYERS);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_ADVANCE, S_DONE, S_ERROR
  } state_e;

  state_e                 state_q;
  logic [2*COORD_W-1:0]   script_mem [DEPTH];
  logic [AW:0]            ptr_q;
  logic [AW:0]            len_q;
  logic [CW-1:0]          cnt_q;
  logic [PW-1:0]          cur_player_q;
  logic [2:0]             throw_idx_q;
  logic [N_PLAYERS-1:0]   done_q;
  logic                   bust_q;
  logic                   dart_come_q;
  logic [COORD_W-1:0]     pos_x_q;
  logic [COORD_W-1:0]     pos_y_q;
  logic                   busy_q;
  logic                   finished_q;
  logic                   timeout_q;
  logic                   wrong_done_q;

  logic                   load_ok;
  logic [N_PLAYERS-1:0]   done_edge;
  logic [N_PLAYERS-1:0]   cur_onehot;
  logic                   cur_edge;
  logic                   other_edge;
  logic [AW:0]            ptr_inc;
  logic                   turn_end;

  assign load_ok    = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
  assign done_edge  = player_done_i & ~done_q;
  assign cur_onehot = N_PLAYERS'(1) << cur_player_q;
  assign cur_edge   = |(done_edge & cur_onehot);
  assign other_edge = |(done_edge & ~cur_onehot);
  assign ptr_inc    = ptr_q + (AW+1)'(1);
  assign turn_end   = (throw_idx_q == 3'(THROWS_PER_TURN - 1)) || bust_q;

  // Script storage is deliberately left out of reset so a reset keeps the loaded game.
  always_ff @(posedge clk) begin
    if (load_en_i && load_ok) begin
      script_mem[load_addr_i] <= {load_x_i, load_y_i};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      cur_player_q <= '0;
      throw_idx_q  <= '0;
      done_q       <= '0;
      bust_q       <= 1'b0;
      dart_come_q  <= 1'b0;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
      timeout_q    <= 1'b0;
      wrong_done_q <= 1'b0;
    end else begin
      done_q       <= player_done_i;
      wrong_done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            len_q        <= script_len_i;
            ptr_q        <= '0;
            cur_player_q <= '0;
            throw_idx_q  <= '0;
            timeout_q    <= 1'b0;
            if (script_len_i == '0) begin
              state_q    <= S_DONE;
              finished_q <= 1'b1;
            end else begin
              state_q    <= S_FETCH;
              busy_q     <= 1'b1;
              finished_q <= 1'b0;
            end
          end
        end
        S_FETCH: begin
          if (game_set_i) begin
            state_q    <= S_DONE;
            busy_q     <= 1'b0;
            finished_q <= 1'b1;
          end else begin
            {pos_x_q, pos_y_q} <= script_mem[ptr_q[AW-1:0]];
            state_q     <= S_WAIT;
            dart_come_q <= 1'b1;
            cnt_q       <= '0;
          end
        end
        S_WAIT: begin
          wrong_done_q <= other_edge;
          // Priority: game over, then the current player's edge, then the watchdog.
          if (game_set_i) begin
            state_q     <= S_DONE;
            dart_come_q <= 1'b0;
            busy_q      <= 1'b0;
            finished_q  <= 1'b1;
          end else if (cur_edge) begin
            state_q     <= S_ADVANCE;
            dart_come_q <= 1'b0;
            bust_q      <= bust_i;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_q     <= S_ERROR;
            dart_come_q <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_ADVANCE: begin
          if (game_set_i) begin
            state_q    <= S_DONE;
            busy_q     <= 1'b0;
            finished_q <= 1'b1;
          end else begin
            ptr_q <= ptr_inc;
            if (turn_end) begin
              throw_idx_q  <= '0;
              cur_player_q <= (cur_player_q == PW'(N_PLAYERS - 1)) ? '0 : cur_player_q + PW'(1);
            end else begin
              throw_idx_q <= throw_idx_q + 3'd1;
            end
            if (ptr_inc == len_q) begin
              state_q    <= S_DONE;
              busy_q     <= 1'b0;
              finished_q <= 1'b1;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          dart_come_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign dart_come_o       = dart_come_q;
  assign dart_position_x_o = pos_x_q;
  assign dart_position_y_o = pos_y_q;
  assign cur_player_o      = cur_player_q;
  assign throw_idx_o       = throw_idx_q;
  assign busy_o            = busy_q;
  assign finished_o        = finished_q;
  assign timeout_o         = timeout_q;
  assign wrong_done_o      = wrong_done_q;

endmodule

// File: tb/tb_dart_throw_sequencer.sv
// Directed bench for dart_throw_sequencer with two players, three throws per turn and a short watchdog.
// Each scenario task drives the block and compares outputs against hand-worked values.
module tb_dart_throw_sequencer;

  localparam int COORD_W = 8;
  localparam int NP      = 2;
  localparam int TPT     = 3;
  localparam int DEPTH   = 32;
  localparam int TO      = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         load_en;
  logic [4:0]   load_addr;
  logic [7:0]   load_x;
  logic [7:0]   load_y;
  logic [5:0]   script_len;
  logic         start;
  logic [1:0]   player_done;
  logic         bust;
  logic         game_set;
  logic         dart_come;
  logic [7:0]   px;
  logic [7:0]   py;
  logic [0:0]   cur_player;
  logic [2:0]   throw_idx;
  logic         busy;
  logic         finished;
  logic         timeout;
  logic         wrong_done;

  int n_checks = 0;
  int n_pass   = 0;

  int ex_x [6] = '{13, 14, 14, 13, 24, 13};
  int ex_y [6] = '{2, 2, 3, 2, 4, 2};
  int ecur [6] = '{0, 0, 0, 1, 1, 1};
  int ethr [6] = '{0, 1, 2, 0, 1, 2};

  dart_throw_sequencer #(
    .COORD_W(COORD_W), .N_PLAYERS(NP), .THROWS_PER_TURN(TPT), .DEPTH(DEPTH), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_x_i(load_x), .load_y_i(load_y),
    .script_len_i(script_len), .start_i(start), .player_done_i(player_done),
    .bust_i(bust), .game_set_i(game_set),
    .dart_come_o(dart_come), .dart_position_x_o(px), .dart_position_y_o(py),
    .cur_player_o(cur_player), .throw_idx_o(throw_idx), .busy_o(busy),
    .finished_o(finished), .timeout_o(timeout), .wrong_done_o(wrong_done)
  );

  task automatic start_play(input int len);
    script_len = 6'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_dart(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dart_come === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_done(input int k, input bit b);
    player_done[k] = 1'b1;
    bust = b;
    @(negedge clk);
    player_done[k] = 1'b0;
    bust = 1'b0;
  endtask

  task automatic end_game();
    game_set = 1'b1;
    @(negedge clk);
    game_set = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    load_en = 0; load_addr = 0; load_x = 0; load_y = 0; script_len = 0;
    start = 0; player_done = 0; bust = 0; game_set = 0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({dart_come, px, py, cur_player, throw_idx, busy, finished, timeout, wrong_done} !== 25'd0)
      $display("FAIL reset_outputs: got %h want 0",
               {dart_come, px, py, cur_player, throw_idx, busy, finished, timeout, wrong_done});
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      load_en = 1'b1; load_addr = 5'(i); load_x = 8'(ex_x[i]); load_y = 8'(ex_y[i]);
      @(negedge clk);
    end
    load_en = 1'b0;
  endtask

  task automatic test_normal_game();
    bit ok;
    start_play(6);
    for (int i = 0; i < 6; i++) begin
      wait_dart(ok);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL normal_dart_%0d: dart_come never rose, want 1", i);
      else n_pass++;
      n_checks++;
      if ({px, py} !== {8'(ex_x[i]), 8'(ex_y[i])})
        $display("FAIL normal_pos_%0d: got (%0d,%0d) want (%0d,%0d)", i, px, py, ex_x[i], ex_y[i]);
      else n_pass++;
      n_checks++;
      if ({cur_player, throw_idx} !== {1'(ecur[i]), 3'(ethr[i])})
        $display("FAIL normal_turn_%0d: got player %0d throw %0d want player %0d throw %0d",
                 i, cur_player, throw_idx, ecur[i], ethr[i]);
      else n_pass++;
      $display("normal throw %0d: pos (%0d,%0d) player %0d throw %0d", i, px, py, cur_player, throw_idx);
      pulse_done(ecur[i], 1'b0);
    end
    @(negedge clk);
    n_checks++;
    if ({finished, busy, dart_come} !== 3'b100)
      $display("FAIL normal_finished: got fin/busy/dart %b want 100", {finished, busy, dart_come});
    else n_pass++;
  endtask

  task automatic test_latency();
    bit ok;
    start_play(6);
    wait_dart(ok);
    pulse_done(0, 1'b0);
    n_checks++;
    if ({dart_come, busy} !== 2'b01) $display("FAIL latency_c1: got dart/busy %b want 01", {dart_come, busy});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (dart_come !== 1'b0) $display("FAIL latency_c2: got dart %b want 0", dart_come);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({dart_come, px} !== {1'b1, 8'd14}) $display("FAIL latency_c3: got dart %b x %0d want 1 x 14", dart_come, px);
    else n_pass++;
    $display("latency: dart %b x %0d after three cycles", dart_come, px);
    end_game();
  endtask

  task automatic test_bust();
    bit ok;
    start_play(6);
    wait_dart(ok);
    pulse_done(0, 1'b1);
    wait_dart(ok);
    n_checks++;
    if ({ok, cur_player, throw_idx} !== {1'b1, 1'b1, 3'd0})
      $display("FAIL bust_turn: got ok %b player %0d throw %0d want 1 1 0", ok, cur_player, throw_idx);
    else n_pass++;
    n_checks++;
    if ({px, py} !== {8'd14, 8'd2}) $display("FAIL bust_pos: got (%0d,%0d) want (14,2)", px, py);
    else n_pass++;
    $display("bust: next player %0d throw %0d pos (%0d,%0d)", cur_player, throw_idx, px, py);
    end_game();
  endtask

  task automatic test_wrong_player();
    bit ok;
    start_play(6);
    wait_dart(ok);
    pulse_done(1, 1'b0);
    n_checks++;
    if ({wrong_done, dart_come, px, py} !== {1'b1, 1'b1, 8'd13, 8'd2})
      $display("FAIL wrong_pulse: got wd %b dart %b (%0d,%0d) want 1 1 (13,2)", wrong_done, dart_come, px, py);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({wrong_done, dart_come, cur_player, px} !== {1'b0, 1'b1, 1'b0, 8'd13})
      $display("FAIL wrong_after: got wd %b dart %b player %0d x %0d want 0 1 0 13", wrong_done, dart_come, cur_player, px);
    else n_pass++;
    start_play(0);
    load_en = 1'b1; load_addr = 5'd0; load_x = 8'd99; load_y = 8'd99;
    @(negedge clk);
    load_en = 1'b0;
    n_checks++;
    if ({dart_come, busy, finished} !== 3'b110)
      $display("FAIL start_ignored: got dart/busy/fin %b want 110", {dart_come, busy, finished});
    else n_pass++;
    $display("wrong player: wd pulse seen, dart %b busy %b", dart_come, busy);
    end_game();
  endtask

  task automatic test_game_set();
    bit ok;
    start_play(6);
    wait_dart(ok);
    player_done[0] = 1'b1;
    game_set = 1'b1;
    @(negedge clk);
    player_done[0] = 1'b0;
    game_set = 1'b0;
    n_checks++;
    if ({finished, busy, dart_come} !== 3'b100)
      $display("FAIL game_set_done: got fin/busy/dart %b want 100", {finished, busy, dart_come});
    else n_pass++;
    n_checks++;
    if ({cur_player, throw_idx} !== 4'd0)
      $display("FAIL game_set_noadv: got player %0d throw %0d want 0 0", cur_player, throw_idx);
    else n_pass++;
    $display("game_set: finished %b throw %0d", finished, throw_idx);
  endtask

  task automatic test_timeout();
    bit ok;
    int cnt;
    start_play(6);
    wait_dart(ok);
    cnt = ok ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dart_come === 1'b1) cnt++;
      else break;
    end
    n_checks++;
    if (cnt !== TO) $display("FAIL timeout_wait: got %0d cycles want %0d", cnt, TO);
    else n_pass++;
    n_checks++;
    if ({timeout, finished, busy, dart_come} !== 4'b1000)
      $display("FAIL timeout_flags: got to/fin/busy/dart %b want 1000", {timeout, finished, busy, dart_come});
    else n_pass++;
    start_play(0);
    n_checks++;
    if ({finished, timeout, busy} !== 3'b100)
      $display("FAIL len_zero: got fin/to/busy %b want 100", {finished, timeout, busy});
    else n_pass++;
    start_play(6);
    n_checks++;
    if ({timeout, finished, busy} !== 3'b001)
      $display("FAIL restart_clear: got to/fin/busy %b want 001", {timeout, finished, busy});
    else n_pass++;
    $display("timeout: %0d wait cycles, restart busy %b", cnt, busy);
    wait_dart(ok);
    end_game();
  endtask

  task automatic test_reset_mid();
    bit ok;
    start_play(6);
    wait_dart(ok);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({dart_come, px, py, cur_player, throw_idx, busy, finished, timeout, wrong_done} !== 25'd0)
      $display("FAIL reset_async: got %h want 0",
               {dart_come, px, py, cur_player, throw_idx, busy, finished, timeout, wrong_done});
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, finished, timeout, dart_come} !== 4'b0000)
      $display("FAIL reset_idle: got busy/fin/to/dart %b want 0000", {busy, finished, timeout, dart_come});
    else n_pass++;
    start_play(6);
    wait_dart(ok);
    n_checks++;
    if ({ok, px, py, cur_player, throw_idx} !== {1'b1, 8'd13, 8'd2, 1'b0, 3'd0})
      $display("FAIL reset_replay: got ok %b (%0d,%0d) player %0d throw %0d want 1 (13,2) 0 0",
               ok, px, py, cur_player, throw_idx);
    else n_pass++;
    $display("reset mid-play: replay starts at (%0d,%0d)", px, py);
    end_game();
  endtask

  initial begin
    test_reset();
    test_normal_game();
    test_latency();
    test_bust();
    test_wrong_player();
    test_game_set();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
